countdown_ctrl: RTL and testbench



---
 rtl/countdown_pkg.sv | 11 +
 rtl/countdown_ctrl_if.sv | 28 ++
 rtl/countdown_ctrl_tick_prescaler.sv | 38 +++
 rtl/countdown_ctrl.sv | 116 +++++++++++
 tb/tb_countdown_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared types for the countdown game timer: FSM state encoding.
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_PAUSE   = 2'b10,
      ST_EXPIRED = 2'b11
   } state_e;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Command/status bundle between game logic (master) and the countdown controller (slave).
interface countdown_ctrl_if #(
   parameter int unsigned TIME_W = 8
) ();

   logic              Load;
   logic [TIME_W-1:0] Load_Val;
   logic              Start;
   logic              Pause;
   logic              Tick;
   logic              Done;
   logic [TIME_W-1:0] Remain;
   logic              Running;
   logic              Paused;
   logic              Expired;
   logic              Half;

   modport master (
      output Load, Load_Val, Start, Pause,
      input  Tick, Done, Remain, Running, Paused, Expired, Half
   );

   modport slave (
      input  Load, Load_Val, Start, Pause,
      output Tick, Done, Remain, Running, Paused, Expired, Half
   );

endinterface

// File: rtl/countdown_ctrl_tick_prescaler.sv
// Programmable timebase: counts enabled cycles and flags the last cycle of each DIV-cycle period.
module tick_prescaler #(
   parameter int unsigned DIV   = 50000000,
   parameter int unsigned CNT_W = 26
) (
   input  logic             Clk_O,
   input  logic             Clear,
   input  logic             en,
   input  logic             rst_cnt,
   output logic [CNT_W-1:0] pre,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] PreMax = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] pre_q, pre_d;

   assign wrap = en && (pre_q == PreMax);
   assign pre  = pre_q;

   always_comb begin
      pre_d = pre_q;
      if (rst_cnt || wrap) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge Clk_O) begin
      if (Clear) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Game-timer controller: loadable seconds countdown sequenced over a prescaler timebase.
module countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int unsigned DIV    = 50000000,
   parameter int unsigned CNT_W  = 26,
   parameter int unsigned TIME_W = 8
) (
   input  logic             Clk_O,
   input  logic             Clear,
   countdown_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0]  HalfDiv = CNT_W'(DIV / 2);
   localparam logic [TIME_W-1:0] OneSec  = TIME_W'(1);

   state_e            state_q, state_d;
   logic [TIME_W-1:0] remain_q, remain_d;
   logic              tick_q, tick_d;
   logic              done_q, done_d;

   logic [CNT_W-1:0]  pre;
   logic              wrap;
   logic              en;
   logic              rst_cnt;

   assign en = (state_q == ST_RUN);

   tick_prescaler #(
      .DIV   (DIV),
      .CNT_W (CNT_W)
   ) u_prescaler (
      .Clk_O   (Clk_O),
      .Clear   (Clear),
      .en      (en),
      .rst_cnt (rst_cnt),
      .pre     (pre),
      .wrap    (wrap)
   );

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      rst_cnt  = 1'b0;
      tick_d   = wrap;
      done_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Load beats a simultaneous Start.
            if (bus.Load) begin
               remain_d = bus.Load_Val;
               rst_cnt  = 1'b1;
            end else if (bus.Start && (remain_q != '0)) begin
               state_d = ST_RUN;
               rst_cnt = 1'b1;
            end
         end

         ST_RUN: begin
            if (wrap && (remain_q != '0)) begin
               remain_d = remain_q - 1'b1;
            end
            // Reaching zero on the wrap edge takes precedence over a pause request.
            if (wrap && (remain_q == OneSec)) begin
               done_d  = 1'b1;
               state_d = ST_EXPIRED;
            end else if (bus.Pause) begin
               state_d = ST_PAUSE;
            end
         end

         ST_PAUSE: begin
            if (bus.Start) begin
               state_d = ST_RUN;
            end
         end

         ST_EXPIRED: begin
            rst_cnt  = 1'b1;
            remain_d = '0;
            if (bus.Load) begin
               state_d  = ST_IDLE;
               remain_d = bus.Load_Val;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk_O) begin
      if (Clear) begin
         state_q  <= ST_IDLE;
         remain_q <= '0;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         tick_q   <= tick_d;
         done_q   <= done_d;
      end
   end

   assign bus.Tick    = tick_q;
   assign bus.Done    = done_q;
   assign bus.Remain  = remain_q;
   assign bus.Running = (state_q == ST_RUN);
   assign bus.Paused  = (state_q == ST_PAUSE);
   assign bus.Expired = (state_q == ST_EXPIRED);
   assign bus.Half    = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && (pre < HalfDiv);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: DIV=4 sequencing with a tick scoreboard, DIV=8 blink wave.
module tb_countdown_ctrl;

   localparam int unsigned TIME_W = 8;

   typedef struct {
      int   cyc;
      int   remain;
      logic done;
   } exp_t;

   logic clk;
   logic clear;
   int   checks;
   int   errors;
   int   cyc;
   int   base;
   exp_t sb[$];

   countdown_ctrl_if #(.TIME_W(TIME_W)) i4 ();
   countdown_ctrl_if #(.TIME_W(TIME_W)) i8 ();

   countdown_ctrl #(
      .DIV    (4),
      .CNT_W  (26),
      .TIME_W (TIME_W)
   ) dut4 (
      .Clk_O (clk),
      .Clear (clear),
      .bus   (i4)
   );

   countdown_ctrl #(
      .DIV    (8),
      .CNT_W  (26),
      .TIME_W (TIME_W)
   ) dut8 (
      .Clk_O (clk),
      .Clear (clear),
      .bus   (i8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every tick of the DIV=4 unit must match the head of the scoreboard.
   task automatic monitor();
      exp_t e;
      if (i4.Tick === 1'b1) begin
         check("tick_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("tick_cycle", cyc, e.cyc);
            check("tick_remain", 32'(i4.Remain), e.remain);
            check("tick_done", 32'(i4.Done), 32'(e.done));
         end
      end else begin
         check("done_without_tick", 32'(i4.Done), 0);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      clear  = 1'b1;
      i4.Load = 1'b0; i4.Load_Val = '0; i4.Start = 1'b0; i4.Pause = 1'b0;
      i8.Load = 1'b0; i8.Load_Val = '0; i8.Start = 1'b0; i8.Pause = 1'b0;
      cycle();
      cycle();
      clear = 1'b0;
      cycle();
      check("rst_remain", 32'(i4.Remain), 0);
      check("rst_running", 32'(i4.Running), 0);
      check("rst_expired", 32'(i4.Expired), 0);
      check("rst_half", 32'(i4.Half), 0);
      check("rst_tick", 32'(i4.Tick), 0);

      // Start with nothing loaded is ignored.
      i4.Start = 1'b1;
      cycle();
      i4.Start = 1'b0;
      check("start_zero_idle", 32'(i4.Running), 0);

      // Load and Start together: load wins.
      i4.Load = 1'b1; i4.Load_Val = 8'd3; i4.Start = 1'b1;
      cycle();
      i4.Load = 1'b0; i4.Start = 1'b0;
      check("load_start_running", 32'(i4.Running), 0);
      check("load_start_remain", 32'(i4.Remain), 3);

      // Full countdown from 3, with a Load during RUN that must be ignored.
      i4.Start = 1'b1;
      cycle();
      i4.Start = 1'b0;
      base = cyc;
      sb.push_back('{base + 4, 2, 1'b0});
      sb.push_back('{base + 8, 1, 1'b0});
      sb.push_back('{base + 12, 0, 1'b1});
      check("run_running", 32'(i4.Running), 1);
      i4.Load = 1'b1; i4.Load_Val = 8'd77;
      cycle();
      i4.Load = 1'b0;
      check("load_in_run", 32'(i4.Remain), 3);
      while (cyc < base + 11) cycle();
      check("not_yet_expired", 32'(i4.Expired), 0);
      cycle();
      check("expired_at_12", 32'(i4.Expired), 1);
      check("expired_half", 32'(i4.Half), 0);
      check("expired_running", 32'(i4.Running), 0);
      cycle();
      cycle();
      check("countdown_sb_empty", 32'(sb.size()), 0);
      check("expired_remain", 32'(i4.Remain), 0);

      // Load from EXPIRED returns to IDLE.
      i4.Load = 1'b1; i4.Load_Val = 8'd2;
      cycle();
      i4.Load = 1'b0;
      check("reload_expired", 32'(i4.Expired), 0);
      check("reload_remain", 32'(i4.Remain), 2);

      // Pause with pre = 2, hold, then resume.
      i4.Start = 1'b1;
      cycle();
      i4.Start = 1'b0;
      cycle();
      i4.Pause = 1'b1;
      cycle();
      check("paused", 32'(i4.Paused), 1);
      check("paused_running", 32'(i4.Running), 0);
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("paused_hold", 32'(i4.Paused), 1);
      end
      i4.Pause = 1'b0;
      check("paused_remain", 32'(i4.Remain), 2);
      i4.Start = 1'b1;
      cycle();
      i4.Start = 1'b0;
      sb.push_back('{cyc + 2, 1, 1'b0});
      sb.push_back('{cyc + 6, 0, 1'b1});
      check("resumed", 32'(i4.Running), 1);
      repeat (7) cycle();
      check("resume_expired", 32'(i4.Expired), 1);
      check("resume_sb_empty", 32'(sb.size()), 0);

      // Pause on the final wrap edge: EXPIRED beats PAUSE.
      i4.Load = 1'b1; i4.Load_Val = 8'd1;
      cycle();
      i4.Load = 1'b0;
      i4.Start = 1'b1;
      cycle();
      i4.Start = 1'b0;
      base = cyc;
      repeat (3) cycle();
      i4.Pause = 1'b1;
      sb.push_back('{base + 4, 0, 1'b1});
      cycle();
      i4.Pause = 1'b0;
      check("wrap_pause_expired", 32'(i4.Expired), 1);
      check("wrap_pause_paused", 32'(i4.Paused), 0);
      check("wrap_pause_sb_empty", 32'(sb.size()), 0);

      // Clear mid-run with Remain = 5.
      i4.Load = 1'b1; i4.Load_Val = 8'd5;
      cycle();
      i4.Load = 1'b0;
      i4.Start = 1'b1;
      cycle();
      i4.Start = 1'b0;
      base = cyc;
      sb.push_back('{base + 4, 4, 1'b0});
      repeat (6) cycle();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      check("clear_remain", 32'(i4.Remain), 0);
      check("clear_running", 32'(i4.Running), 0);
      check("clear_paused", 32'(i4.Paused), 0);
      check("clear_expired", 32'(i4.Expired), 0);
      check("clear_half", 32'(i4.Half), 0);
      check("clear_tick", 32'(i4.Tick), 0);
      check("clear_done", 32'(i4.Done), 0);
      repeat (6) cycle();
      check("clear_sb_empty", 32'(sb.size()), 0);

      // Blink wave on the DIV=8 unit.
      check("half_idle", 32'(i8.Half), 0);
      i8.Load = 1'b1; i8.Load_Val = 8'd2;
      cycle();
      i8.Load = 1'b0;
      i8.Start = 1'b1;
      cycle();
      i8.Start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check("half_run", 32'(i8.Half), 32'((k % 8) < 4));
         cycle();
      end
      check("half_div8_expired", 32'(i8.Expired), 1);
      check("half_after_expiry", 32'(i8.Half), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
